// File: rtl/dff_pipeline.sv
// Elastic WIDTH x DEPTH register pipeline with valid/ready on both sides,
// bubble collapse, synchronous flush and a registered occupancy count.
module dff_pipeline #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_v;
  logic [CNT_W-1:0] r_count;

  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_load;
  logic [DEPTH-1:0] w_mv;
  logic [WIDTH-1:0] w_src [DEPTH];
  logic             w_space;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // Advance chain: a stage moves when it is valid and the stage after it has room.
  always_comb begin
    w_adv   = '0;
    w_space = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_adv[i] = r_v[i] & w_space;
      w_space  = ~r_v[i] | w_adv[i];
    end
  end

  assign w_load     = ~r_v | w_adv;
  assign in_ready   = ~flush & w_load[0];
  assign out_valid  = r_v[DEPTH-1] & ~flush;
  assign out_data   = r_data[DEPTH-1];
  assign count      = r_count;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  // Per-stage source word and whether a valid word moves in this cycle.
  for (genvar g = 0; g < DEPTH; g++) begin : g_src
    if (g == 0) begin : g_head
      assign w_src[g] = in_data;
      assign w_mv[g]  = w_in_xfer;
    end else begin : g_body
      assign w_src[g] = r_data[g-1];
      assign w_mv[g]  = w_adv[g-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v     <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else if (flush) begin
      r_v     <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_load[i]) begin
          r_v[i] <= w_mv[i];
          if (w_mv[i]) begin
            r_data[i] <= w_src[i];
          end
        end
      end
      if (w_in_xfer && !w_out_xfer) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_in_xfer && w_out_xfer) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dff_pipeline.sv
// Directed self-checking bench for dff_pipeline (WIDTH=8, DEPTH=4).
module tb_dff_pipeline;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       flush;
  logic [2:0] count;

  int n_tests;
  int n_fail;

  dff_pipeline #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1; flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || count !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_hold c=%0d: valid=%b data=%h count=%0d, want 0/00/0",
                 c, out_valid, out_data, count);
      end
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_stream();
    int acc, emit, exp_cnt;
    logic exp_v;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 6);
      in_data  = 8'(8'h11 + c);
      tick();
      exp_v = (c >= 3) && (c <= 8);
      acc   = (c + 1 < 6) ? c + 1 : 6;
      emit  = (c - 3 < 0) ? 0 : ((c - 3 > 6) ? 6 : c - 3);
      exp_cnt = acc - emit;
      n_tests++;
      if (out_valid !== exp_v || (exp_v && out_data !== 8'(8'h11 + c - 3))) begin
        n_fail++;
        $display("FAIL stream_out c=%0d: valid=%b data=%h, want valid=%b data=%h",
                 c, out_valid, out_data, exp_v, 8'(8'h11 + c - 3));
      end
      n_tests++;
      if (count !== 3'(exp_cnt)) begin
        n_fail++;
        $display("FAIL stream_count c=%0d: got %0d want %0d", c, count, exp_cnt);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int acc;
    logic acc_now;
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h21 + acc);
      #1;
      n_tests++;
      if (in_ready !== (acc < 4)) begin
        n_fail++;
        $display("FAIL bp_in_ready c=%0d: got %b want %b", c, in_ready, acc < 4);
      end
      acc_now = in_valid & in_ready;
      tick();
      if (acc_now) acc++;
    end
    n_tests++;
    if (acc != 4 || count !== 3'd4 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: accepted=%0d count=%0d in_ready=%b, want 4/4/0", acc, count, in_ready);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 7; j++) begin
      in_valid = (acc < 6);
      in_data  = 8'(8'h21 + acc);
      #1;
      n_tests++;
      if (out_valid !== (j < 6) || (j < 6 && out_data !== 8'(8'h21 + j))) begin
        n_fail++;
        $display("FAIL bp_drain j=%0d: valid=%b data=%h, want valid=%b data=%h",
                 j, out_valid, out_data, j < 6, 8'(8'h21 + j));
      end
      acc_now = in_valid & in_ready;
      tick();
      if (acc_now) acc++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL bp_empty_count: got %0d want 0", count);
    end
  endtask

  task automatic test_bubble();
    logic [7:0] pat [7];
    logic       pv  [7];
    pat = '{8'hA0, 8'h00, 8'h00, 8'hA1, 8'h00, 8'hA2, 8'hA3};
    pv  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      in_valid = pv[c];
      in_data  = pat[c];
      if (c == 6) begin
        #1;
        n_tests++;
        if (count !== 3'd3 || out_data !== 8'hA0 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL bubble_collapse: count=%0d data=%h valid=%b in_ready=%b, want 3/a0/1/1",
                   count, out_data, out_valid, in_ready);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || count !== 3'd4) begin
      n_fail++;
      $display("FAIL bubble_full: in_ready=%b count=%0d, want 0/4", in_ready, count);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 8'(8'hA0 + j)) begin
        n_fail++;
        $display("FAIL bubble_drain j=%0d: valid=%b data=%h, want 1/%h",
                 j, out_valid, out_data, 8'(8'hA0 + j));
      end
      tick();
    end
  endtask

  task automatic test_flush();
    logic seen;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (c < 3);
      in_data  = 8'(8'hB0 + c);
      tick();
    end
    in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1; flush = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_handshake: in_ready=%b out_valid=%b, want 0/0", in_ready, out_valid);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_tests++;
    if (count !== 3'd0) begin
      n_fail++;
      $display("FAIL flush_count: got %0d want 0", count);
    end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid === 1'b1) seen = 1'b1;
      tick();
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_output: out_valid seen=%b want 0", seen);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hC0 + c);
      tick();
    end
    in_valid = 1'b0;
    n_tests++;
    if (count !== 3'd4 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_fill: count=%0d valid=%b, want 4/1", count, out_valid);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL areset_async: valid=%b count=%0d, want 0/0", out_valid, count);
    end
    tick();
    #2 reset = 1'b1;
    tick();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    for (int c = 0; c < 4; c++) begin
      tick();
      in_valid = 1'b0;
      n_tests++;
      if (out_valid !== (c == 3) || (c == 3 && out_data !== 8'h77)) begin
        n_fail++;
        $display("FAIL areset_next c=%0d: valid=%b data=%h, want valid=%b data=77",
                 c, out_valid, out_data, c == 3);
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; flush = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
